// File: rtl/ras_pkg.sv
// Shared decode constants, instruction classes and FSM states for the RAS
// prediction controller.
package ras_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  // IC_ICALL is a JALR whose rd is a link: it pushes like a call but is
  // predicted like any other indirect jump.
  typedef enum logic [2:0] {
    IC_OTHER, IC_CALL, IC_ICALL, IC_RET, IC_CORET, IC_BR, IC_IND
  } instr_class_e;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

  function automatic instr_class_e classify(input logic [31:0] ins);
    logic [4:0] rd, rs1;
    rd  = ins[11:7];
    rs1 = ins[19:15];
    case (ins[6:0])
      OPC_JAL:    return is_link(rd) ? IC_CALL : IC_OTHER;
      OPC_JALR: begin
        if (is_link(rd) && is_link(rs1) && (rd != rs1)) return IC_CORET;
        if ((rd == 5'd0) && is_link(rs1))              return IC_RET;
        if (is_link(rd))                               return IC_ICALL;
        return IC_IND;
      end
      OPC_BRANCH: return IC_BR;
      default:    return IC_OTHER;
    endcase
  endfunction

  function automatic logic needs_ckpt(input instr_class_e c);
    return (c == IC_ICALL) || (c == IC_RET) || (c == IC_CORET) ||
           (c == IC_BR) || (c == IC_IND);
  endfunction

endpackage

// File: rtl/ras_ctrl_fifo.sv
// In-order FIFO of checkpoint tags; oldest entry is exposed on head_o.
module ras_ctrl_fifo
  import ras_pkg::*;
#(
  parameter int W        = 32,
  parameter int DEPTH    = 2,
  parameter int CntWidth = $clog2(DEPTH+1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [W-1:0]        data_i,
  input  logic                pop_i,
  input  logic                clear_i,
  output logic [W-1:0]        head_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]        r_mem [DEPTH];
  logic [PtrW-1:0]     r_wr, r_rd;
  logic [CntWidth-1:0] r_count;
  logic                w_push, w_pop;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = push_i && (r_count != CntWidth'(DEPTH));
  assign w_pop   = pop_i && (r_count != '0);
  assign head_o  = r_mem[r_rd];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      r_count <= r_count + CntWidth'(w_push) - CntWidth'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wr] <= data_i;
  end

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-stage return-address-stack controller: decodes calls/returns/branches,
// drives RAS strobes, tracks checkpoints in order and recovers on mispredict.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DatapathWidth     = 32,
  parameter int NumTosCheckpoints = 2,
  parameter int CntWidth          = $clog2(NumTosCheckpoints+1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [DatapathWidth-1:0] fetch_pc_i,
  input  logic [31:0]              fetch_instr_i,
  output logic                     pred_valid_o,
  output logic                     pred_taken_o,
  output logic [DatapathWidth-1:0] pred_target_o,
  input  logic                     resolve_valid_i,
  input  logic [DatapathWidth-1:0] resolve_pc_i,
  input  logic                     resolve_mispredict_i,
  input  logic [DatapathWidth-1:0] resolve_target_i,
  output logic                     redirect_valid_o,
  output logic [DatapathWidth-1:0] redirect_pc_o,
  output logic                     ras_push_o,
  output logic                     ras_pop_o,
  output logic [DatapathWidth-1:0] ras_pc_o,
  input  logic [DatapathWidth-1:0] ras_pc_i,
  output logic                     ras_make_checkpoint_o,
  output logic [DatapathWidth-1:0] ras_make_checkpoint_pc_o,
  output logic                     ras_restore_checkpoint_o,
  output logic [DatapathWidth-1:0] ras_restore_checkpoint_pc_o,
  output logic [CntWidth-1:0]      outstanding_o,
  output logic                     order_error_o
);

  localparam int DW = DatapathWidth;

  state_e              r_state, w_state_nxt;
  logic                r_redirect_valid, r_order_err;
  logic [DW-1:0]       r_redirect_pc;
  instr_class_e        w_cls;
  logic                w_need_ckpt, w_full, w_fire, w_mispred, w_res_ok;
  logic [DW-1:0]       w_pc4, w_imm_j, w_imm_b, w_head;
  logic [CntWidth-1:0] w_count;

  assign w_cls       = classify(fetch_instr_i);
  assign w_need_ckpt = needs_ckpt(w_cls);
  assign w_imm_j = {{(DW-21){fetch_instr_i[31]}}, fetch_instr_i[31], fetch_instr_i[19:12],
                    fetch_instr_i[20], fetch_instr_i[30:21], 1'b0};
  assign w_imm_b = {{(DW-13){fetch_instr_i[31]}}, fetch_instr_i[31], fetch_instr_i[7],
                    fetch_instr_i[30:25], fetch_instr_i[11:8], 1'b0};
  assign w_pc4   = fetch_pc_i + DW'(4);

  assign w_full    = (w_count == CntWidth'(NumTosCheckpoints));
  assign w_mispred = resolve_valid_i && resolve_mispredict_i && (r_state == ST_RUN);
  assign w_res_ok  = resolve_valid_i && !resolve_mispredict_i && (r_state == ST_RUN);

  // Full check uses the registered count: a same-cycle dequeue does not free a slot.
  assign fetch_ready_o = (r_state == ST_RUN) && !(resolve_valid_i && resolve_mispredict_i) &&
                         !(w_full && w_need_ckpt);
  assign w_fire        = fetch_valid_i && fetch_ready_o;

  always_comb begin
    pred_valid_o             = w_fire;
    pred_taken_o             = 1'b0;
    pred_target_o            = '0;
    ras_push_o               = 1'b0;
    ras_pop_o                = 1'b0;
    ras_pc_o                 = '0;
    ras_make_checkpoint_o    = 1'b0;
    ras_make_checkpoint_pc_o = '0;
    if (w_fire) begin
      pred_target_o            = w_pc4;
      ras_make_checkpoint_o    = w_need_ckpt;
      ras_make_checkpoint_pc_o = w_need_ckpt ? fetch_pc_i : '0;
      case (w_cls)
        IC_CALL: begin
          ras_push_o    = 1'b1;
          ras_pc_o      = w_pc4;
          pred_taken_o  = 1'b1;
          pred_target_o = fetch_pc_i + w_imm_j;
        end
        IC_ICALL: begin
          ras_push_o = 1'b1;
          ras_pc_o   = w_pc4;
        end
        IC_RET: begin
          ras_pop_o     = 1'b1;
          pred_taken_o  = 1'b1;
          pred_target_o = ras_pc_i;
        end
        IC_CORET: begin
          ras_pop_o     = 1'b1;
          ras_push_o    = 1'b1;
          ras_pc_o      = w_pc4;
          pred_taken_o  = 1'b1;
          pred_target_o = ras_pc_i;
        end
        IC_BR: begin
          // Static backward-taken / forward-not-taken.
          pred_taken_o  = w_imm_b[DW-1];
          pred_target_o = w_imm_b[DW-1] ? fetch_pc_i + w_imm_b : w_pc4;
        end
        default: ;
      endcase
    end
  end

  assign ras_restore_checkpoint_o    = w_mispred;
  assign ras_restore_checkpoint_pc_o = w_mispred ? resolve_pc_i : '0;

  ras_ctrl_fifo #(.W(DW), .DEPTH(NumTosCheckpoints), .CntWidth(CntWidth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ras_make_checkpoint_o),
    .data_i  (fetch_pc_i),
    .pop_i   (w_res_ok),
    .clear_i (w_mispred),
    .head_o  (w_head),
    .count_o (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_mispred) w_state_nxt = ST_FLUSH;
      ST_FLUSH: w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_RUN;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_order_err      <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_redirect_valid <= w_mispred;
      if (w_mispred) r_redirect_pc <= resolve_target_i;
      if (w_res_ok && ((w_count == '0) || (resolve_pc_i != w_head))) r_order_err <= 1'b1;
    end
  end

  // Reset arriving while the redirect is on the bus must hide it immediately.
  assign redirect_valid_o = r_redirect_valid && !rst_i;
  assign redirect_pc_o    = r_redirect_pc;
  assign outstanding_o    = w_count;
  assign order_error_o    = r_order_err;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed scoreboard bench for ras_ctrl: expected fetch-side responses are
// queued as stimulus is driven and compared when the DUT responds.
module tb_ras_ctrl;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_valid, fetch_ready;
  logic [DW-1:0] fetch_pc;
  logic [31:0]   fetch_instr;
  logic          pred_valid, pred_taken;
  logic [DW-1:0] pred_target;
  logic          res_valid, res_mis;
  logic [DW-1:0] res_pc, res_tgt;
  logic          redir_valid;
  logic [DW-1:0] redir_pc;
  logic          ras_push, ras_pop;
  logic [DW-1:0] ras_pc_out, ras_top;
  logic          mk_ck, rs_ck;
  logic [DW-1:0] mk_ck_pc, rs_ck_pc;
  logic [CW-1:0] outstanding;
  logic          order_err;

  ras_ctrl #(.DatapathWidth(DW), .NumTosCheckpoints(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr),
    .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .resolve_valid_i(res_valid), .resolve_pc_i(res_pc),
    .resolve_mispredict_i(res_mis), .resolve_target_i(res_tgt),
    .redirect_valid_o(redir_valid), .redirect_pc_o(redir_pc),
    .ras_push_o(ras_push), .ras_pop_o(ras_pop), .ras_pc_o(ras_pc_out), .ras_pc_i(ras_top),
    .ras_make_checkpoint_o(mk_ck), .ras_make_checkpoint_pc_o(mk_ck_pc),
    .ras_restore_checkpoint_o(rs_ck), .ras_restore_checkpoint_pc_o(rs_ck_pc),
    .outstanding_o(outstanding), .order_error_o(order_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic rdy, pv, tk;
    logic [31:0] tgt;
    logic push, pop;
    logic [31:0] rpc;
    logic ck;
    logic [31:0] ckpc;
    logic rs;
    logic [31:0] rspc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] e_jal(input logic [4:0] rd, input int imm);
    logic [31:0] i;
    i = imm;
    return {i[20], i[10:1], i[11], i[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] e_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, 7'h67};
  endfunction

  function automatic logic [31:0] e_br(input int imm);
    logic [31:0] i;
    i = imm;
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'h63};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic exp_t x_idle(input logic rdy);
    exp_t e;
    e = '{rdy: rdy, pv: 1'b0, tk: 1'b0, tgt: '0, push: 1'b0, pop: 1'b0,
          rpc: '0, ck: 1'b0, ckpc: '0, rs: 1'b0, rspc: '0};
    return e;
  endfunction

  function automatic exp_t x_f(input logic tk, input logic [31:0] tgt, input logic push,
                               input logic pop, input logic [31:0] rpc, input logic ck,
                               input logic [31:0] ckpc);
    exp_t e;
    e = '{rdy: 1'b1, pv: 1'b1, tk: tk, tgt: tgt, push: push, pop: pop,
          rpc: rpc, ck: ck, ckpc: ckpc, rs: 1'b0, rspc: '0};
    return e;
  endfunction

  task automatic clr();
    fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0; ras_top = '0;
    res_valid = 1'b0; res_pc = '0; res_mis = 1'b0; res_tgt = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] top);
    fetch_valid = 1'b1; fetch_pc = pc; fetch_instr = ins; ras_top = top;
  endtask

  task automatic res(input logic [31:0] pc, input logic mis, input logic [31:0] tgt);
    res_valid = 1'b1; res_pc = pc; res_mis = mis; res_tgt = tgt;
  endtask

  task automatic chk_comb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ready"}, 64'(fetch_ready), 64'(e.rdy));
      chk({tag, "_pvalid"}, 64'(pred_valid), 64'(e.pv));
      chk({tag, "_taken"}, 64'(pred_taken), 64'(e.tk));
      chk({tag, "_target"}, 64'(pred_target), 64'(e.tgt));
      chk({tag, "_push"}, 64'(ras_push), 64'(e.push));
      chk({tag, "_pop"}, 64'(ras_pop), 64'(e.pop));
      chk({tag, "_raspc"}, 64'(ras_pc_out), 64'(e.rpc));
      chk({tag, "_mkck"}, 64'(mk_ck), 64'(e.ck));
      chk({tag, "_mkckpc"}, 64'(mk_ck_pc), 64'(e.ckpc));
      chk({tag, "_rsck"}, 64'(rs_ck), 64'(e.rs));
      chk({tag, "_rsckpc"}, 64'(rs_ck_pc), 64'(e.rspc));
    end
  endtask

  task automatic step_begin();
    @(negedge clk);
    clr();
  endtask

  exp_t ex;

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_order", 64'(order_err), 64'd0);
    chk("rst_redir_v", 64'(redir_valid), 64'd0);
    chk("rst_redir_pc", 64'(redir_pc), 64'd0);

    // JAL x1 call: push pc+4, jump pc+imm
    step_begin(); rst = 1'b0;
    fetch(32'h100, e_jal(5'd1, 32'h40), 32'h0);
    sb.push_back(x_f(1, 32'h140, 1, 0, 32'h104, 0, 32'h0));
    #1 chk_comb("jal_call");

    // Return: pop, target from RAS top, checkpoint
    step_begin();
    fetch(32'h180, e_jalr(5'd0, 5'd1), 32'h104);
    sb.push_back(x_f(1, 32'h104, 0, 1, 32'h0, 1, 32'h180));
    #1 chk_comb("ret");

    step_begin();
    res(32'h180, 1'b0, 32'h0);
    sb.push_back(x_idle(1));
    #1 chk_comb("res_ret");
    chk("ret_outstanding", 64'(outstanding), 64'd1);

    // Coroutine return: push and pop together
    step_begin();
    fetch(32'h400, e_jalr(5'd5, 5'd1), 32'h500);
    sb.push_back(x_f(1, 32'h500, 1, 1, 32'h404, 1, 32'h400));
    #1 chk_comb("coret");
    chk("coret_pre_outst", 64'(outstanding), 64'd0);

    step_begin();
    fetch(32'h10, NOP, 32'h0);
    res(32'h400, 1'b0, 32'h0);
    sb.push_back(x_f(0, 32'h14, 0, 0, 32'h0, 0, 32'h0));
    #1 chk_comb("nop");
    chk("coret_outst", 64'(outstanding), 64'd1);

    // Two branches fill the checkpoint FIFO
    step_begin();
    fetch(32'h200, e_br(32'h20), 32'h0);
    sb.push_back(x_f(0, 32'h204, 0, 0, 32'h0, 1, 32'h200));
    #1 chk_comb("br_fwd");
    chk("br0_outst", 64'(outstanding), 64'd0);
    chk("br0_order", 64'(order_err), 64'd0);

    step_begin();
    fetch(32'h210, e_br(-32'sd16), 32'h0);
    sb.push_back(x_f(1, 32'h200, 0, 0, 32'h0, 1, 32'h210));
    #1 chk_comb("br_bwd");

    step_begin();
    fetch(32'h220, e_br(32'h8), 32'h0);
    sb.push_back(x_idle(0));
    #1 chk_comb("br_full_stall");
    chk("full_outst", 64'(outstanding), 64'd2);

    // Dequeue in the same cycle does not unblock the stalled branch
    step_begin();
    fetch(32'h220, e_br(32'h8), 32'h0);
    res(32'h200, 1'b0, 32'h0);
    sb.push_back(x_idle(0));
    #1 chk_comb("br_nobypass");

    step_begin();
    fetch(32'h220, e_br(32'h8), 32'h0);
    sb.push_back(x_f(0, 32'h224, 0, 0, 32'h0, 1, 32'h220));
    #1 chk_comb("br_unstall");
    chk("unstall_outst", 64'(outstanding), 64'd1);
    chk("unstall_order", 64'(order_err), 64'd0);

    // Mispredict: restore now, redirect next cycle, FIFO cleared
    step_begin();
    fetch(32'h30, NOP, 32'h0);
    res(32'h210, 1'b1, 32'h300);
    ex = x_idle(0); ex.rs = 1'b1; ex.rspc = 32'h210;
    sb.push_back(ex);
    #1 chk_comb("mispred");
    chk("mis_pre_outst", 64'(outstanding), 64'd2);

    step_begin();
    fetch(32'h30, NOP, 32'h0);
    res(32'h999, 1'b0, 32'h0);
    sb.push_back(x_idle(0));
    #1 chk_comb("flush");
    chk("flush_redir_v", 64'(redir_valid), 64'd1);
    chk("flush_redir_pc", 64'(redir_pc), 64'h300);
    chk("flush_outst", 64'(outstanding), 64'd0);

    // Simultaneous correct resolve and checkpointing fetch
    step_begin();
    fetch(32'h600, e_br(32'h10), 32'h0);
    sb.push_back(x_f(0, 32'h604, 0, 0, 32'h0, 1, 32'h600));
    #1 chk_comb("br600");
    chk("postflush_redir_v", 64'(redir_valid), 64'd0);
    chk("flush_res_ignored", 64'(order_err), 64'd0);

    step_begin();
    fetch(32'h610, e_br(32'h4), 32'h0);
    res(32'h600, 1'b0, 32'h0);
    sb.push_back(x_f(0, 32'h614, 0, 0, 32'h0, 1, 32'h610));
    #1 chk_comb("enq_deq");
    chk("enq_deq_pre", 64'(outstanding), 64'd1);

    // Out-of-order resolve sets the sticky error
    step_begin();
    res(32'h999, 1'b0, 32'h0);
    sb.push_back(x_idle(1));
    #1 chk_comb("res_bad");
    chk("enq_deq_outst", 64'(outstanding), 64'd1);
    chk("pre_bad_order", 64'(order_err), 64'd0);

    step_begin();
    res(32'h777, 1'b0, 32'h0);
    sb.push_back(x_idle(1));
    #1 chk_comb("res_empty");
    chk("order_set", 64'(order_err), 64'd1);
    chk("bad_outst", 64'(outstanding), 64'd0);

    // PC wrap-around
    step_begin();
    fetch(32'h0, e_br(-32'sd4), 32'h0);
    sb.push_back(x_f(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 1, 32'h0));
    #1 chk_comb("br_wrap");
    chk("order_sticky", 64'(order_err), 64'd1);

    step_begin();
    fetch(32'hFFFF_FFFC, e_jal(5'd1, 32'h8), 32'h0);
    sb.push_back(x_f(1, 32'h4, 1, 0, 32'h0, 0, 32'h0));
    #1 chk_comb("jal_wrap");

    step_begin();
    res(32'h0, 1'b1, 32'h800);
    ex = x_idle(0); ex.rs = 1'b1; ex.rspc = 32'h0;
    sb.push_back(ex);
    #1 chk_comb("mispred2");

    // Reset during FLUSH hides the redirect
    step_begin();
    rst = 1'b1;
    sb.push_back(x_idle(0));
    #1 chk_comb("rst_flush");
    chk("rst_flush_redir", 64'(redir_valid), 64'd0);

    step_begin();
    rst = 1'b0;
    sb.push_back(x_idle(1));
    #1 chk_comb("post_rst");
    chk("post_rst_redir_v", 64'(redir_valid), 64'd0);
    chk("post_rst_redir_pc", 64'(redir_pc), 64'd0);
    chk("post_rst_order", 64'(order_err), 64'd0);
    chk("post_rst_outst", 64'(outstanding), 64'd0);

    // Plain indirect jump: checkpoint, fall-through prediction
    step_begin();
    fetch(32'h700, e_jalr(5'd2, 5'd3), 32'h0);
    sb.push_back(x_f(0, 32'h704, 0, 0, 32'h0, 1, 32'h700));
    #1 chk_comb("ind");

    step_begin();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DatapathWidth, default 32, PC and address width.
REQ-002 SHALL have parameter NumTosCheckpoints, default 2, equal to the RAS checkpoint count; CntWidth = $clog2(NumTosCheckpoints+1).
REQ-003 Ports, one clock; reset is synchronous and active-high:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
fetch_valid_i  in  1  fetched instruction valid
fetch_ready_o  out  1  instruction accepted when valid&ready
fetch_pc_i  in  DW  instruction PC
fetch_instr_i  in  32  RV32 instruction word
pred_valid_o  out  1  prediction valid, equals fetch handshake
pred_taken_o  out  1  predicted redirect
pred_target_o  out  DW  predicted target
resolve_valid_i  in  1  execute resolves oldest checkpointed instruction
resolve_pc_i  in  DW  PC of resolved instruction
resolve_mispredict_i  in  1  prediction wrong
resolve_target_i  in  DW  correct next PC
redirect_valid_o  out  1  fetch redirect
redirect_pc_o  out  DW  redirect address
ras_push_o, ras_pop_o  out  1  RAS push/pop
ras_pc_o  out  DW  return address to push
ras_pc_i  in  DW  RAS top-of-stack value
ras_make_checkpoint_o  out  1  RAS checkpoint request
ras_make_checkpoint_pc_o  out  DW  checkpoint tag
ras_restore_checkpoint_o  out  1  RAS restore request
ras_restore_checkpoint_pc_o  out  DW  restore tag
outstanding_o  out  CntWidth  live checkpoints
order_error_o  out  1  sticky resolve-order error

Function
REQ-004 Decode, on handshake only: link = x1 or x5; CALL = JAL/JALR with rd link; RET = JALR, rd=x0, rs1 link; CORET = JALR, rd and rs1 both link, rd!=rs1; BR = opcode 1100011; IND = JALR not RET/CORET.
REQ-005 CALL: ras_push_o=1, ras_pc_o=fetch_pc_i+4; JAL target pc+imm_J, taken=1.
REQ-006 RET: ras_pop_o=1, pred_target_o=ras_pc_i, taken=1; CORET: pop and push same cycle, target ras_pc_i.
REQ-007 BR: make checkpoint, tag fetch_pc_i; taken=1 iff imm_B negative, target pc+imm_B, else pc+4.
REQ-008 IND and RET/CORET also make checkpoint; IND predicts pc+4, taken=0.
REQ-009 Non-control instructions: taken=0, target pc+4, no RAS strobes.
REQ-010 All RAS strobes and pred_* SHALL be combinational, zero when no handshake.
REQ-011 Checkpoint tags SHALL enter an in-order FIFO of depth NumTosCheckpoints; outstanding_o = occupancy.
REQ-012 fetch_ready_o=0 when: state FLUSH; resolve_valid_i&resolve_mispredict_i; or outstanding_o==NumTosCheckpoints and the instruction needs a checkpoint (decided on registered count; no same-cycle dequeue bypass).
REQ-013 Correct resolve: head dequeued; resolve_pc_i!=head or FIFO empty sets order_error_o.
REQ-014 Mispredict: ras_restore_checkpoint_o=1 combinationally, tag resolve_pc_i; FIFO cleared; next cycle redirect_valid_o=1, redirect_pc_o=resolve_target_i.
REQ-015 FSM: RUN -> FLUSH on mispredict; FLUSH -> RUN after exactly one cycle; resolve during FLUSH is ignored.
REQ-016 Simultaneous correct resolve and checkpointing fetch (non-full): dequeue and enqueue both occur; count unchanged.
REQ-017 PC arithmetic SHALL wrap modulo 2^DatapathWidth.

Reset
REQ-018 On rst_i: state RUN, FIFO empty, outstanding_o=0, order_error_o=0, redirect_valid_o=0, redirect_pc_o=0; reset wins over every concurrent event.
REQ-019 Reset mid-FLUSH SHALL suppress the pending redirect.

Structure
REQ-020 Package ras_pkg SHALL hold opcode constants (JAL, JALR, BRANCH), link register indices, and the instruction-class enum.
REQ-021 Checkpoint FIFO SHALL be sub-module ras_ctrl_fifo (push, pop, clear, head, count).

Verification
REQ-022 Fetch JAL x1, pc 0x100, imm +0x40 -> push, ras_pc_o=0x104, target 0x140, taken.
REQ-023 Fetch JALR x0,0(x1) with ras_pc_i=0x104 -> pop, target 0x104, checkpoint tag at its PC.
REQ-024 Two BR fetches (pc 0x200, 0x210) then third BR -> third stalls, outstanding_o=2, until a correct resolve of 0x200.
REQ-025 Resolve 0x200 mispredict, target 0x300 -> restore tag 0x200 same cycle; next cycle redirect 0x300; outstanding_o=0; fetch blocked one cycle.
REQ-026 Correct resolve 0x210 with head 0x200 -> order_error_o=1, sticky until rst_i.
REQ-027 rst_i asserted during FLUSH -> no redirect, all outputs at reset values next cycle.
